// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per requester (cpu, dbg).
//   master : requester view (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter view
//   req    : access request, held with its fields until gnt
//   we     : 1 = store, 0 = load
//   addr   : word address
//   wdata  : store data
//   gnt    : one-cycle pulse, access issued to memory this cycle
//   rvalid : one-cycle pulse, rdata valid
//   rdata  : load data, held until the next load by this requester
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port data memory.
// One access outstanding at a time; writes complete at the grant edge, reads wait
// MEM_LAT cycles and return data to the requester that owned the grant.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   cpu, dbg    : requester buses (dmem_arbiter_if.slave)
//   mem_en      : memory access strobe
//   mem_we      : memory write enable, meaningful with mem_en
//   mem_addr    : memory address (cpu fields when idle)
//   mem_wdata   : memory write data (cpu fields when idle)
//   mem_rdata   : memory read data, valid MEM_LAT cycles after mem_en
//   busy        : high while a read is outstanding
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dbg,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_prio;      // 0 = cpu has priority, 1 = dbg
    logic              r_owner;     // 0 = cpu owns the outstanding read, 1 = dbg
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic w_idle;
    logic w_cpu_win;
    logic w_dbg_win;
    logic w_grant;
    logic w_we;

    // Arbitration; rst_n gates grants so nothing issues while reset is held.
    always_comb begin
        w_idle    = rst_n && (r_state == S_IDLE);
        w_cpu_win = w_idle && cpu.req && (!dbg.req || !r_prio);
        w_dbg_win = w_idle && dbg.req && (!cpu.req ||  r_prio);
        w_grant   = w_cpu_win || w_dbg_win;
        w_we      = w_dbg_win ? dbg.we : (w_cpu_win && cpu.we);
    end

    // Memory-side mux; cpu fields drive the bus when nobody wins.
    always_comb begin
        mem_en    = w_grant;
        mem_we    = w_we;
        mem_addr  = w_dbg_win ? dbg.addr  : cpu.addr;
        mem_wdata = w_dbg_win ? dbg.wdata : cpu.wdata;
    end

    assign busy       = (r_state == S_WAIT);
    assign cpu.gnt    = w_cpu_win;
    assign dbg.gnt    = w_dbg_win;
    assign cpu.rvalid = r_cpu_rvalid;
    assign dbg.rvalid = r_dbg_rvalid;
    assign cpu.rdata  = r_cpu_rdata;
    assign dbg.rdata  = r_dbg_rdata;

    // Sequencer: counter holds remaining wait cycles; capture when it reaches 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        // Priority passes to the requester that did not win.
                        r_prio <= w_cpu_win;
                        if (!w_we) begin
                            r_owner <= w_dbg_win;
                            r_cnt   <= CNT_W'(MEM_LAT);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_owner) begin
                            r_dbg_rdata  <= mem_rdata;
                            r_dbg_rvalid <= 1'b1;
                        end else begin
                            r_cpu_rdata  <= mem_rdata;
                            r_cpu_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory of the single-cycle MIPS core.
- Shares the memory between the processor load/store path (cpu port) and a debug/loader port (dbg port). The dbg port lets the bench or loader preload and inspect data memory at run time instead of only by file load.
- Sits between the core's lw/sw datapath and the data memory instance. Enforces one outstanding access at a time and applies round-robin fairness.

Parameters:
- ADDR_W, 8, word address width of the data memory.
- DATA_W, 16, data word width; matches the ALU/register width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  processor access request; held with its fields until cpu_gnt.
- cpu_we  in  1  1 = store (sw), 0 = load (lw).
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_gnt  out  1  one-cycle pulse: access issued to memory this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  load data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same widths and semantics as the cpu_* ports, for the debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only meaningful when mem_en=1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high while a read is outstanding.

Behaviour:
- States:
  - IDLE: can grant.
  - WAIT: read outstanding; count MEM_LAT cycles.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, priority pointer=cpu, latency counter=0, owner=cpu.
  - rvalid=0 on both ports; rdata=0 on both ports.
  - busy=0, mem_en=0, both gnt=0.
  - An in-flight read is dropped; no rvalid is ever produced for it.
- IDLE arbitration (combinational):
  - Only one of cpu_req/dbg_req asserted: that requester wins.
  - Both asserted: the requester the priority pointer names wins.
  - Winner: gnt=1 and mem_en=1 in the same cycle; mem_we/mem_addr/mem_wdata are muxed from the winner.
  - Loser: gnt=0; it keeps req and its fields stable.
  - No request: mem_en=0; mem_addr/mem_wdata hold the cpu fields; mem_we=0.
- Priority pointer:
  - On every grant it moves to the non-winning requester (round-robin).
  - With no grant it is unchanged.
- Write grant:
  - Write completes at the grant edge; state stays IDLE.
  - The next grant is possible in the next cycle (one write per cycle sustained).
- Read grant (cycle T):
  - Record the owner; go to WAIT; load counter=MEM_LAT.
  - In WAIT: busy=1, no grants, mem_en=0; the counter decrements each cycle.
  - At the edge ending cycle T+MEM_LAT: capture mem_rdata into owner_rdata, set owner_rvalid=1, return to IDLE.
  - owner_rvalid is high for exactly one cycle (T+MEM_LAT+1). owner_rdata holds its value until the next read by that owner.
  - Total read latency: gnt to rvalid = MEM_LAT+1 cycles.
  - A new grant may occur in the same cycle rvalid is high (back-to-back reads).
- gnt is never asserted when req is low. gnt is never asserted on both ports in the same cycle.
- Request dropped before grant: legal; no access occurs.
- Request changed after grant: ignored.
- The rvalid and rdata of the non-owner port are unchanged by the other port's traffic.
- The datapath is width-transparent: no arithmetic on address or data.

Test Plan:
- cpu_req only: sw addr 0x05 data 0x1234; then lw addr 0x05 (MEM_LAT=1) -> cpu_gnt on the same cycle as req for each; cpu_rvalid 2 cycles after the lw grant with cpu_rdata=0x1234; dbg_gnt never asserted.
- Both reqs high from reset, both writes -> grants alternate cpu, dbg, cpu, dbg on consecutive cycles; mem_en=1 every cycle.
- cpu read in flight (MEM_LAT=3), dbg_req raised one cycle after the grant -> busy=1 for 3 cycles; dbg_gnt in the cycle cpu_rvalid pulses; dbg_rvalid 4 cycles later.
- Preload memory 0x00AA at addr 0x10 via dbg write, then cpu lw 0x10 -> cpu_rdata=0x00AA; dbg_rdata unchanged.
- rst_n pulled low during WAIT -> rvalid stays 0; busy=0 and mem_en=0 immediately; after release, the first simultaneous request is granted to cpu.
